puck_frame_sequencer: RTL and testbench

//  Consumer end of the frame-tick interface: waits for a frame tick, acknowledges it by pulsing

---
 rtl/air_hockey_pkg.sv | 25 ++
 rtl/block_pixel_scanner.sv | 45 ++++
 rtl/puck_frame_sequencer.sv | 167 ++++++++++++++++
 tb/tb_puck_frame_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/air_hockey_pkg.sv
// Shared definitions for the air-hockey display blocks: screen geometry,
// colour constants, coordinate widths and the puck sequencer state encoding.
package air_hockey_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    // VGA adapter write-port widths
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] BG_COLOUR   = 3'b000;
    localparam logic [COLOUR_W-1:0] PUCK_COLOUR = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ERASE,
        UPDATE,
        DRAW,
        DONE
    } seq_state_t;

endpackage

// File: rtl/block_pixel_scanner.sv
// Walks the pixels of a 2**PUCK_LOG2 square in row-major order from a base
// corner, one pixel per cycle, after a single-cycle start pulse.
module block_pixel_scanner
    import air_hockey_pkg::*;
#(
    parameter int PUCK_LOG2 = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [X_W-1:0]   base_x,
    input  logic [Y_W-1:0]   base_y,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic             active,
    output logic             last
);

    localparam int OFS_W = 2 * PUCK_LOG2;

    logic [OFS_W-1:0] offset;

    // The offset wraps back to zero naturally on the final pixel.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            active <= 1'b0;
            offset <= '0;
        end else if (start) begin
            active <= 1'b1;
            offset <= '0;
        end else if (active) begin
            offset <= offset + 1'b1;
            if (last) begin
                active <= 1'b0;
            end
        end
    end

    always_comb begin
        last = active && (offset == {OFS_W{1'b1}});
        x    = base_x + X_W'(offset[PUCK_LOG2-1:0]);
        y    = base_y + Y_W'(offset[OFS_W-1:PUCK_LOG2]);
    end

endmodule

// File: rtl/puck_frame_sequencer.sv
// Frame-tick consumer: acknowledges each tick, erases the puck, steps it with
// wall bounce, and redraws it through the VGA adapter write port.
module puck_frame_sequencer
    import air_hockey_pkg::*;
#(
    parameter int                   SCREEN_W    = air_hockey_pkg::SCREEN_W,
    parameter int                   SCREEN_H    = air_hockey_pkg::SCREEN_H,
    parameter int                   PUCK_LOG2   = 2,
    parameter int                   X_INIT      = 78,
    parameter int                   Y_INIT      = 58,
    parameter logic [COLOUR_W-1:0]  BG_COLOUR   = air_hockey_pkg::BG_COLOUR,
    parameter logic [COLOUR_W-1:0]  PUCK_COLOUR = air_hockey_pkg::PUCK_COLOUR
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 frame_tick,
    output logic                 frame_clear,
    output logic [X_W-1:0]       x,
    output logic [Y_W-1:0]       y,
    output logic [COLOUR_W-1:0]  colour,
    output logic                 plot,
    output logic [X_W-1:0]       puck_x,
    output logic [Y_W-1:0]       puck_y,
    output logic                 busy,
    output logic                 overrun
);

    localparam int             PSZ   = 1 << PUCK_LOG2;
    localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - PSZ);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - PSZ);

    seq_state_t state;
    seq_state_t state_next;

    logic tick_d;
    logic tick_rise;
    logic dir_x;   // 1 = moving right
    logic dir_y;   // 1 = moving down

    logic                scan_start;
    logic [X_W-1:0]      scan_x;
    logic [Y_W-1:0]      scan_y;
    logic                scan_active;
    logic                scan_last;

    logic [X_W-1:0]      x_hold;
    logic [Y_W-1:0]      y_hold;
    logic [COLOUR_W-1:0] colour_hold;
    logic [COLOUR_W-1:0] colour_now;

    assign tick_rise = frame_tick & ~tick_d;

    // One scanner serves both passes; the base switches to the new position
    // at the end of UPDATE, so ERASE sees the old corner and DRAW the new one.
    block_pixel_scanner #(
        .PUCK_LOG2 (PUCK_LOG2)
    ) u_scanner (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (scan_start),
        .base_x  (puck_x),
        .base_y  (puck_y),
        .x       (scan_x),
        .y       (scan_y),
        .active  (scan_active),
        .last    (scan_last)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            tick_d      <= 1'b0;
            puck_x      <= X_W'(X_INIT);
            puck_y      <= Y_W'(Y_INIT);
            dir_x       <= 1'b1;
            dir_y       <= 1'b1;
            x_hold      <= '0;
            y_hold      <= '0;
            colour_hold <= '0;
        end else begin
            state  <= state_next;
            tick_d <= frame_tick;

            if (plot) begin
                x_hold      <= scan_x;
                y_hold      <= scan_y;
                colour_hold <= colour_now;
            end

            if (state == UPDATE) begin
                if (dir_x && (puck_x == X_MAX)) begin
                    dir_x  <= 1'b0;
                    puck_x <= puck_x - 1'b1;
                end else if (!dir_x && (puck_x == '0)) begin
                    dir_x  <= 1'b1;
                    puck_x <= X_W'(1);
                end else begin
                    puck_x <= dir_x ? puck_x + 1'b1 : puck_x - 1'b1;
                end

                if (dir_y && (puck_y == Y_MAX)) begin
                    dir_y  <= 1'b0;
                    puck_y <= puck_y - 1'b1;
                end else if (!dir_y && (puck_y == '0)) begin
                    dir_y  <= 1'b1;
                    puck_y <= Y_W'(1);
                end else begin
                    puck_y <= dir_y ? puck_y + 1'b1 : puck_y - 1'b1;
                end
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_next = state;
        scan_start = 1'b0;
        case (state)
            IDLE: begin
                if (tick_rise && enable) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                scan_start = 1'b1;
                state_next = ERASE;
            end
            ERASE: begin
                if (scan_last) begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                scan_start = 1'b1;
                state_next = DRAW;
            end
            DRAW: begin
                if (scan_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pixel port shows the live scan while plotting, else the last pixel written.
    always_comb begin
        busy        = (state != IDLE);
        frame_clear = (state == CLEAR);
        overrun     = tick_rise && busy;
        plot        = scan_active;
        colour_now  = (state == DRAW) ? PUCK_COLOUR : BG_COLOUR;
        x           = plot ? scan_x     : x_hold;
        y           = plot ? scan_y     : y_hold;
        colour      = plot ? colour_now : colour_hold;
    end

endmodule

// File: tb/tb_puck_frame_sequencer.sv
// Scoreboard bench for puck_frame_sequencer: expected pixels are queued per
// pass and a negedge monitor compares every plotted pixel against the queue.
module tb_puck_frame_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       frame_tick = 1'b0;
    logic       frame_clear;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic [7:0] puck_x;
    logic [6:0] puck_y;
    logic       busy;
    logic       overrun;

    // second instance starts in the bottom-right corner
    logic       frame_tick_c = 1'b0;
    logic       frame_clear_c;
    logic [7:0] x_c;
    logic [6:0] y_c;
    logic [2:0] colour_c;
    logic       plot_c;
    logic [7:0] puck_x_c;
    logic [6:0] puck_y_c;
    logic       busy_c;
    logic       overrun_c;

    always #5 clock = ~clock;

    puck_frame_sequencer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .frame_tick  (frame_tick),
        .frame_clear (frame_clear),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .puck_x      (puck_x),
        .puck_y      (puck_y),
        .busy        (busy),
        .overrun     (overrun)
    );

    puck_frame_sequencer #(
        .X_INIT (156),
        .Y_INIT (116)
    ) dut_corner (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .frame_tick  (frame_tick_c),
        .frame_clear (frame_clear_c),
        .x           (x_c),
        .y           (y_c),
        .colour      (colour_c),
        .plot        (plot_c),
        .puck_x      (puck_x_c),
        .puck_y      (puck_y_c),
        .busy        (busy_c),
        .overrun     (overrun_c)
    );

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int fc_count = 0;
    int ov_count = 0;
    int plot_count = 0;

    int exp_px = 78;
    int exp_py = 58;
    bit exp_dx = 1'b1;
    bit exp_dy = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_step();
        if (exp_dx && exp_px == 156) begin exp_dx = 1'b0; exp_px = 155; end
        else if (!exp_dx && exp_px == 0) begin exp_dx = 1'b1; exp_px = 1; end
        else exp_px = exp_dx ? exp_px + 1 : exp_px - 1;
        if (exp_dy && exp_py == 116) begin exp_dy = 1'b0; exp_py = 115; end
        else if (!exp_dy && exp_py == 0) begin exp_dy = 1'b1; exp_py = 1; end
        else exp_py = exp_dy ? exp_py + 1 : exp_py - 1;
    endfunction

    task automatic push_pass();
        pix_t p;
        for (int i = 0; i < 16; i++) begin
            p.x = 8'(exp_px + i % 4); p.y = 7'(exp_py + i / 4); p.c = 3'd0;
            sb.push_back(p);
        end
        model_step();
        for (int i = 0; i < 16; i++) begin
            p.x = 8'(exp_px + i % 4); p.y = 7'(exp_py + i / 4); p.c = 3'd7;
            sb.push_back(p);
        end
    endtask

    always @(negedge clock) begin
        pix_t p;
        if (frame_clear === 1'b1) fc_count++;
        if (overrun === 1'b1) ov_count++;
        if (plot === 1'b1) begin
            plot_count++;
            if (sb.size() == 0) begin
                check("unexpected_plot", 32'(plot), 32'd0);
            end else begin
                p = sb.pop_front();
                check("pix_x", 32'(x), 32'(p.x));
                check("pix_y", 32'(y), 32'(p.y));
                check("pix_colour", 32'(colour), 32'(p.c));
            end
        end
    end

    // Waits for busy to rise then fall; returns on a negedge.
    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        int n = 0;
        while (n < 10 && busy !== 1'b1) begin @(negedge clock); n++; end
        n = 0;
        while (n < 120) begin
            @(negedge clock);
            if (busy === 1'b0) begin ok = 1'b1; break; end
            n++;
        end
        check({name, "_complete"}, 32'(ok), 32'd1);
    endtask

    task automatic do_pass();
        push_pass();
        frame_tick = 1'b1;
        wait_idle("pass");
        frame_tick = 1'b0;
        @(posedge clock); #1;
        check("puck_x", 32'(puck_x), 32'(exp_px));
        check("puck_y", 32'(puck_y), 32'(exp_py));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic fc_s   [0:47];
        logic plot_s [0:47];
        logic busy_s [0:47];
        int fc0, ov0, pl0, fc_sum, ov_sum, pl_sum;

        // reset state
        reset_n = 1'b0;
        enable  = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        check("rst_x", 32'(x), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_colour", 32'(colour), 32'd0);
        check("rst_plot", 32'(plot), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_clear", 32'(frame_clear), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_puck_x", 32'(puck_x), 32'd78);
        check("rst_puck_y", 32'(puck_y), 32'd58);

        // corner bounce on the second instance
        frame_tick_c = 1'b1;
        repeat (60) @(posedge clock);
        #1 frame_tick_c = 1'b0;
        check("corner_x", 32'(puck_x_c), 32'd155);
        check("corner_y", 32'(puck_y_c), 32'd115);
        @(posedge clock); #1 frame_tick_c = 1'b1;
        repeat (60) @(posedge clock);
        #1 frame_tick_c = 1'b0;
        check("corner_x_dir", 32'(puck_x_c), 32'd154);
        check("corner_y_dir", 32'(puck_y_c), 32'd114);
        @(posedge clock); #1;

        // first pass with cycle-level timing
        push_pass();
        frame_tick = 1'b1;
        for (int s = 0; s < 48; s++) begin
            @(negedge clock);
            fc_s[s] = frame_clear; plot_s[s] = plot; busy_s[s] = busy;
        end
        frame_tick = 1'b0;
        fc_sum = 0; pl_sum = 0;
        for (int s = 0; s < 48; s++) begin
            fc_sum += int'(fc_s[s]);
            pl_sum += int'(plot_s[s]);
        end
        check("t1_busy_before", 32'(busy_s[0]), 32'd0);
        check("t1_clear_at_n1", 32'(fc_s[1]), 32'd1);
        check("t1_clear_count", 32'(fc_sum), 32'd1);
        check("t1_no_plot_in_clear", 32'(plot_s[1]), 32'd0);
        check("t1_erase_first", 32'(plot_s[2]), 32'd1);
        check("t1_erase_last", 32'(plot_s[17]), 32'd1);
        check("t1_update_gap", 32'(plot_s[18]), 32'd0);
        check("t1_draw_first", 32'(plot_s[19]), 32'd1);
        check("t1_draw_last", 32'(plot_s[34]), 32'd1);
        check("t1_done_no_plot", 32'(plot_s[35]), 32'd0);
        check("t1_busy_done", 32'(busy_s[35]), 32'd1);
        check("t1_busy_fall", 32'(busy_s[36]), 32'd0);
        check("t1_plot_count", 32'(pl_sum), 32'd32);
        @(posedge clock); #1;
        check("t1_puck_x", 32'(puck_x), 32'd79);
        check("t1_puck_y", 32'(puck_y), 32'd59);

        // second tick edge during ERASE
        fc0 = fc_count; ov0 = ov_count; pl0 = plot_count;
        push_pass();
        frame_tick = 1'b1;
        repeat (4) @(posedge clock);
        #1 frame_tick = 1'b0;
        @(posedge clock); #1 frame_tick = 1'b1;
        wait_idle("t4");
        check("t4_overrun_count", 32'(ov_count - ov0), 32'd1);
        check("t4_clear_count", 32'(fc_count - fc0), 32'd1);
        check("t4_plot_count", 32'(plot_count - pl0), 32'd32);
        repeat (20) @(negedge clock);
        check("t4_no_restart", 32'(fc_count - fc0), 32'd1);
        check("t4_idle", 32'(busy), 32'd0);
        frame_tick = 1'b0;
        @(posedge clock); #1;
        check("t4_puck_x", 32'(puck_x), 32'd80);
        check("t4_puck_y", 32'(puck_y), 32'd60);

        // tick held high for 1000 cycles
        fc0 = fc_count; ov0 = ov_count; pl0 = plot_count;
        push_pass();
        frame_tick = 1'b1;
        repeat (1000) @(negedge clock);
        fc_sum = fc_count - fc0; ov_sum = ov_count - ov0;
        check("t6_clear_count", 32'(fc_sum), 32'd1);
        check("t6_overrun_count", 32'(ov_sum), 32'd0);
        check("t6_plot_count", 32'(plot_count - pl0), 32'd32);
        check("t6_idle", 32'(busy), 32'd0);
        frame_tick = 1'b0;
        @(posedge clock); #1;
        check("t6_puck_x", 32'(puck_x), 32'd81);
        check("t6_puck_y", 32'(puck_y), 32'd61);

        // right wall, then left wall
        for (int k = 0; k < 400 && !(exp_px == 156 && exp_dx); k++) do_pass();
        check("t2_at_right", 32'(puck_x), 32'd156);
        do_pass();
        check("t2_bounce_right", 32'(puck_x), 32'd155);
        do_pass();
        check("t2_moving_left", 32'(puck_x), 32'd154);
        for (int k = 0; k < 400 && !(exp_px == 0 && !exp_dx); k++) do_pass();
        check("t2_at_left", 32'(puck_x), 32'd0);
        do_pass();
        check("t2_bounce_left", 32'(puck_x), 32'd1);
        do_pass();
        check("t2_moving_right", 32'(puck_x), 32'd2);

        // enable falls mid-pass: pass completes, then nothing new
        fc0 = fc_count; pl0 = plot_count;
        push_pass();
        frame_tick = 1'b1;
        repeat (5) @(posedge clock);
        #1 enable = 1'b0;
        wait_idle("t5_en");
        frame_tick = 1'b0;
        check("t5_en_clear", 32'(fc_count - fc0), 32'd1);
        check("t5_en_plots", 32'(plot_count - pl0), 32'd32);
        @(posedge clock); #1;
        check("t5_en_puck_x", 32'(puck_x), 32'(exp_px));
        frame_tick = 1'b1;
        repeat (60) @(negedge clock);
        check("t5_dis_clear", 32'(fc_count - fc0), 32'd1);
        check("t5_dis_plots", 32'(plot_count - pl0), 32'd32);
        check("t5_dis_busy", 32'(busy), 32'd0);
        frame_tick = 1'b0;
        enable = 1'b1;
        repeat (10) @(negedge clock);
        check("t5_no_fresh_tick", 32'(busy), 32'd0);

        // reset during DRAW
        @(posedge clock); #1;
        push_pass();
        frame_tick = 1'b1;
        begin
            bit seen = 1'b0;
            for (int n = 0; n < 60 && !seen; n++) begin
                @(negedge clock);
                if (plot === 1'b1 && colour === 3'd7) seen = 1'b1;
            end
            check("t5_reach_draw", 32'(seen), 32'd1);
        end
        @(posedge clock); #1 reset_n = 1'b0;
        @(posedge clock); #1;
        sb.delete();
        check("t5_rst_plot", 32'(plot), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_puck_x", 32'(puck_x), 32'd78);
        check("t5_rst_puck_y", 32'(puck_y), 32'd58);
        check("t5_rst_colour", 32'(colour), 32'd0);
        frame_tick = 1'b0;
        reset_n = 1'b1;
        exp_px = 78; exp_py = 58; exp_dx = 1'b1; exp_dy = 1'b1;
        @(posedge clock); #1;
        do_pass();
        check("t5_after_rst_x", 32'(puck_x), 32'd79);
        check("t5_after_rst_y", 32'(puck_y), 32'd59);

        repeat (5) @(negedge clock);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
